// File: rtl/jk_bank_driver.sv
// Drives a bank of external JK flops to a requested value from the JK excitation table.
// Each drive is checked against Q feedback and retried a bounded number of times.

module jk_exc_lane #(
    parameter int TOGGLE_MODE = 0
) (
    input  logic       q,
    input  logic       t,
    output logic [1:0] jk
);
    always_comb begin
        jk = 2'b00;
        if (q != t) jk = (TOGGLE_MODE != 0) ? 2'b11 : {t, ~t};
    end
endmodule

module jk_bank_driver #(
    parameter int WIDTH       = 4,
    parameter int TOGGLE_MODE = 0,
    parameter int MAX_RETRY   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tgt_valid,
    input  logic [WIDTH-1:0]   tgt,
    output logic               tgt_ready,
    input  logic [WIDTH-1:0]   q_fb,
    output logic [2*WIDTH-1:0] jk,
    output logic               busy,
    output logic               done,
    output logic               err
);
    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

    state_t                  state, state_d;
    logic [WIDTH-1:0]        tgt_r, tgt_d, exc_tgt;
    logic [3:0]              retry_cnt, retry_d;
    logic [2*WIDTH-1:0]      jk_d;
    logic                    done_d, err_d;
    logic [WIDTH-1:0][1:0]   lane_jk;

    // Excitation is taken against the live request in IDLE, the latched copy on retries.
    assign exc_tgt = (state == IDLE) ? tgt : tgt_r;

    jk_exc_lane #(.TOGGLE_MODE(TOGGLE_MODE)) u_lane [WIDTH-1:0] (
        .q  (q_fb),
        .t  (exc_tgt),
        .jk (lane_jk)
    );

    assign busy      = (state != IDLE);
    assign tgt_ready = (state == IDLE) & rst_n;

    always_comb begin
        state_d = state;
        tgt_d   = tgt_r;
        retry_d = retry_cnt;
        jk_d    = '0;
        done_d  = 1'b0;
        err_d   = err;
        case (state)
            IDLE: begin
                if (tgt_valid && tgt_ready) begin
                    tgt_d   = tgt;
                    err_d   = 1'b0;
                    retry_d = '0;
                    jk_d    = lane_jk;
                    state_d = DRIVE;
                end
            end
            DRIVE: state_d = CHECK;
            CHECK: begin
                if (q_fb == tgt_r) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (retry_cnt < 4'(MAX_RETRY)) begin
                    retry_d = retry_cnt + 4'd1;
                    jk_d    = lane_jk;
                    state_d = DRIVE;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tgt_r     <= '0;
            retry_cnt <= '0;
            jk        <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            tgt_r     <= tgt_d;
            retry_cnt <= retry_d;
            jk        <= jk_d;
            done      <= done_d;
            err       <= err_d;
        end
    end
endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: two instances (set/reset and toggle codes) each driving a modelled JK bank.
// Directed table, randomized requests against a transaction-level predictor, and reset corners.

module tb_jk_bank_driver;
    localparam int MAXR = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tgt_valid;
    logic [3:0] tgt;
    logic [3:0] stuck;
    logic [3:0] qa = 4'b0, qb = 4'b0;
    logic       rdy0, rdy1, busy0, busy1, done0, done1, err0, err1;
    logic [7:0] jk0, jk1;
    int         cyc = 0;
    int         total = 0, bad = 0;
    int         prev_acc = 0, prev_n = 0;
    bit         prev_chain = 0;

    jk_bank_driver #(.WIDTH(4), .TOGGLE_MODE(0), .MAX_RETRY(MAXR)) u0 (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt(tgt), .tgt_ready(rdy0),
        .q_fb(qa), .jk(jk0), .busy(busy0), .done(done0), .err(err0));
    jk_bank_driver #(.WIDTH(4), .TOGGLE_MODE(1), .MAX_RETRY(MAXR)) u1 (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt(tgt), .tgt_ready(rdy1),
        .q_fb(qb), .jk(jk1), .busy(busy1), .done(done1), .err(err1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] step(input logic [3:0] q, input logic [7:0] j);
        logic [3:0] n;
        for (int i = 0; i < 4; i++) n[i] = (j[2*i+1] & ~q[i]) | (~j[2*i] & q[i]);
        return n;
    endfunction

    // External bank: stuck bits are forced low regardless of drive.
    always @(posedge clk) begin
        qa <= step(qa, jk0) & ~stuck;
        qb <= step(qb, jk1) & ~stuck;
    end

    function automatic logic [7:0] exc(input logic [3:0] q, input logic [3:0] t, input bit tm);
        logic [3:0] d, j, k;
        logic [7:0] r;
        d = q ^ t;
        j = tm ? d : (d & t);
        k = tm ? d : (d & ~t);
        for (int i = 0; i < 4; i++) begin
            r[2*i+1] = j[i];
            r[2*i]   = k[i];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [11:0] obs0();
        return {busy0, done0, err0, rdy0, jk0};
    endfunction
    function automatic logic [11:0] obs1();
        return {busy1, done1, err1, rdy1, jk1};
    endfunction

    task automatic wait_ready(output bit ok);
        int w = 0;
        while (!(rdy0 && rdy1) && w < 8) begin
            @(negedge clk);
            w++;
        end
        ok = rdy0 && rdy1;
        if (!ok) chk("ready wait", {11'b0, rdy0 & rdy1}, 12'd1);
    endtask

    task automatic do_req(input logic [3:0] t, input logic [3:0] s, input bit poke, input bit chain,
                          input bit use_tbl, input logic [7:0] tj0, input logic [7:0] tj1, input bit tok);
        logic [3:0] q;
        logic [7:0] x0 [0:MAXR];
        logic [7:0] x1 [0:MAXR];
        logic [7:0] e0, e1;
        int         n2, acc;
        bit         ok, eok, can_space, r;
        can_space = prev_chain;
        if (s != stuck) begin
            stuck = s;
            @(negedge clk);
            can_space = 0;
        end
        wait_ready(r);
        if (!r) begin
            prev_chain = 0;
            return;
        end
        // Predict: each attempt lands unstuck bits on target, so the bank reads t & ~s afterwards.
        q  = qa;
        ok = 0;
        n2 = 0;
        for (int a = 0; a <= MAXR; a++) begin
            x0[a] = 8'h00;
            x1[a] = 8'h00;
            if (!ok) begin
                x0[a] = exc(q, t, 1'b0);
                x1[a] = exc(q, t, 1'b1);
                q  = t & ~s;
                n2 = 2 * (a + 1);
                ok = (q == t);
            end
        end
        eok = use_tbl ? tok : ok;
        tgt_valid = 1'b1;
        tgt       = t;
        acc       = 0;
        for (int e = 0; e <= n2; e++) begin
            @(negedge clk);
            if (e == 0) begin
                acc = cyc;
                if (can_space) chk("b2b spacing", 12'(acc - prev_acc), 12'(prev_n + 1));
                if (poke) tgt = 4'hF;
                else begin
                    tgt_valid = 1'b0;
                    tgt       = ~t;
                end
            end
            if (poke && e == n2 - 1) tgt_valid = 1'b0;
            e0 = 8'h00;
            e1 = 8'h00;
            if (e < n2 && e % 2 == 0) begin
                e0 = (e == 0 && use_tbl) ? tj0 : x0[e/2];
                e1 = (e == 0 && use_tbl) ? tj1 : x1[e/2];
            end
            chk($sformatf("u0 t=%b e=%0d", t, e), obs0(),
                {e < n2, e == n2 && eok, e == n2 && !eok, e == n2, e0});
            chk($sformatf("u1 t=%b e=%0d", t, e), obs1(),
                {e < n2, e == n2 && eok, e == n2 && !eok, e == n2, e1});
        end
        chk("bank u0", {8'b0, qa}, {8'b0, q});
        chk("bank u1", {8'b0, qb}, {8'b0, q});
        prev_acc   = acc;
        prev_n     = n2;
        prev_chain = chain;
        if (!chain) begin
            @(negedge clk);
            chk("idle u0", {busy0, done0, err0, rdy0}, {3'b000, 1'b1} | {2'b00, !eok, 1'b0});
            chk("idle u1", {busy1, done1, err1, rdy1}, {3'b000, 1'b1} | {2'b00, !eok, 1'b0});
        end
    endtask

    typedef struct {
        logic [3:0] t;
        logic [3:0] stuck;
        bit         poke;
        bit         chain;
        logic [7:0] j0;
        logic [7:0] j1;
        bit         ok;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] qsave, t;
        bit         r;
        tbl[0] = '{4'b1010, 4'b0000, 0, 0, 8'b10_00_10_00, 8'b11_00_11_00, 1};
        tbl[1] = '{4'b0110, 4'b0000, 0, 0, 8'b01_10_00_00, 8'b11_11_00_00, 1};
        tbl[2] = '{4'b0110, 4'b0000, 0, 0, 8'b00_00_00_00, 8'b00_00_00_00, 1};
        tbl[3] = '{4'b0001, 4'b0001, 0, 0, 8'b00_01_01_10, 8'b00_11_11_11, 0};
        tbl[4] = '{4'b1111, 4'b0000, 0, 0, 8'b10_10_10_10, 8'b11_11_11_11, 1};
        tbl[5] = '{4'b0000, 4'b0000, 1, 0, 8'b01_01_01_01, 8'b11_11_11_11, 1};
        tbl[6] = '{4'b0011, 4'b0000, 0, 1, 8'b00_00_10_10, 8'b00_00_11_11, 1};
        tbl[7] = '{4'b1100, 4'b0000, 0, 0, 8'b10_10_01_01, 8'b11_11_11_11, 1};

        rst_n = 1'b0;
        tgt_valid = 1'b0;
        tgt = 4'h0;
        stuck = 4'h0;
        #1;
        chk("reset u0", obs0(), 12'h000);
        chk("reset u1", obs1(), 12'h000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post reset u0", obs0(), 12'h100);
        chk("post reset u1", obs1(), 12'h100);

        foreach (tbl[i])
            do_req(tbl[i].t, tbl[i].stuck, tbl[i].poke, tbl[i].chain, 1'b1, tbl[i].j0, tbl[i].j1, tbl[i].ok);

        // Reset clears a sticky err with no clock edge.
        do_req(4'b0100, 4'b0100, 0, 0, 0, 8'h00, 8'h00, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst err u0", obs0(), 12'h000);
        chk("rst err u1", obs1(), 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst err rdy u0", obs0(), 12'h100);
        prev_chain = 0;

        // Reset in the middle of DRIVE: bank must not be driven.
        stuck = 4'h0;
        @(negedge clk);
        wait_ready(r);
        qsave = qa;
        t = ~qa;
        tgt_valid = 1'b1;
        tgt = t;
        @(negedge clk);
        tgt_valid = 1'b0;
        chk("drive u0", obs0(), {4'b1000, exc(qsave, t, 1'b0)});
        chk("drive u1", obs1(), {4'b1000, exc(qsave, t, 1'b1)});
        #1 rst_n = 1'b0;
        #1;
        chk("rst drive u0", obs0(), 12'h000);
        chk("rst drive u1", obs1(), 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst drive rdy u0", obs0(), 12'h100);
        chk("rst drive rdy u1", obs1(), 12'h100);
        chk("bank untouched", {8'b0, qa}, {8'b0, qsave});
        prev_chain = 0;

        for (int n = 0; n < 60; n++) begin
            logic [3:0] rt, rs;
            rt = 4'($urandom_range(0, 15));
            rs = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
            do_req(rt, rs, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 0, 8'h00, 8'h00, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
